// File: rtl/hazard_ctrl_mc.sv
// Hazard unit for the 5-stage MIPS pipeline: forwarding, load-use,
// multi-cycle MDU stall, trap drain and a saturating stall counter.
module hazard_ctrl_mc #(
    parameter int REG_AW     = 5,
    parameter int MDU_LAT    = 4,
    parameter int TRAP_DRAIN = 2,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite_EM,
    input  logic              RegWrite_MW,
    input  logic              MemRead_DE,
    input  logic              Branch_taken,
    input  logic              mdu_start,
    input  logic              Overflow,
    input  logic              Break,
    input  logic              uses_rt_FD,
    input  logic [REG_AW-1:0] WriteReg_EM,
    input  logic [REG_AW-1:0] WriteReg_MW,
    input  logic [REG_AW-1:0] RS_DE,
    input  logic [REG_AW-1:0] RT_DE,
    input  logic [REG_AW-1:0] RS_FD,
    input  logic [REG_AW-1:0] RT_FD,
    output logic [1:0]        PCSrc,
    output logic [1:0]        ForwardA,
    output logic [1:0]        ForwardB,
    output logic              Stall_PC,
    output logic              Stall_FD,
    output logic              Stall_DE,
    output logic              flush_FD,
    output logic              flush_DE,
    output logic              trap_busy,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int MAXC = (MDU_LAT > TRAP_DRAIN) ? MDU_LAT : TRAP_DRAIN;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_WAIT = 2'd1,
        TRAP     = 2'd2
    } state_t;

    state_t        state, nstate;
    logic [CW-1:0] cnt, ncnt;
    logic          exc, load_use;

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (RegWrite_EM && WriteReg_EM != '0 && src == WriteReg_EM)
            sel = 2'b10;
        else if (RegWrite_MW && WriteReg_MW != '0 && src == WriteReg_MW)
            sel = 2'b01;
        return sel;
    endfunction

    assign ForwardA = fwd_sel(RS_DE);
    assign ForwardB = fwd_sel(RT_DE);

    assign exc      = Overflow | Break;
    assign load_use = MemRead_DE && RT_DE != '0 &&
                      (RT_DE == RS_FD || (uses_rt_FD && RT_DE == RT_FD));

    always_comb begin
        PCSrc     = 2'b00;
        Stall_PC  = 1'b0;
        Stall_FD  = 1'b0;
        Stall_DE  = 1'b0;
        flush_FD  = 1'b0;
        flush_DE  = 1'b0;
        trap_busy = 1'b0;
        nstate    = state;
        ncnt      = cnt;
        case (state)
            TRAP: begin
                Stall_PC  = 1'b1;
                flush_FD  = 1'b1;
                flush_DE  = 1'b1;
                trap_busy = 1'b1;
                if (cnt == '0) nstate = RUN;
                else           ncnt   = cnt - 1'b1;
            end
            MDU_WAIT: begin
                if (exc) begin
                    PCSrc    = 2'b11;
                    flush_FD = 1'b1;
                    flush_DE = 1'b1;
                    nstate   = TRAP;
                    ncnt     = CW'(TRAP_DRAIN - 1);
                end else begin
                    Stall_PC = 1'b1;
                    Stall_FD = 1'b1;
                    Stall_DE = 1'b1;
                    if (cnt == '0) nstate = RUN;
                    else           ncnt   = cnt - 1'b1;
                end
            end
            default: begin
                if (exc) begin
                    PCSrc    = 2'b11;
                    flush_FD = 1'b1;
                    flush_DE = 1'b1;
                    nstate   = TRAP;
                    ncnt     = CW'(TRAP_DRAIN - 1);
                end else if (mdu_start) begin
                    Stall_PC = 1'b1;
                    Stall_FD = 1'b1;
                    Stall_DE = 1'b1;
                    // the RUN cycle itself is the first of MDU_LAT stalls
                    if (MDU_LAT > 1) begin
                        nstate = MDU_WAIT;
                        ncnt   = CW'(MDU_LAT - 2);
                    end
                end else if (Branch_taken) begin
                    PCSrc    = 2'b01;
                    flush_FD = 1'b1;
                    flush_DE = 1'b1;
                end else if (load_use) begin
                    Stall_PC = 1'b1;
                    Stall_FD = 1'b1;
                    flush_DE = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            cnt         <= '0;
            stall_count <= '0;
        end else begin
            state <= nstate;
            cnt   <= ncnt;
            if (Stall_PC && stall_count != {CNT_W{1'b1}})
                stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Scoreboard bench for hazard_ctrl_mc: expected outputs are queued
// as stimulus is driven and compared at the following falling edge.
module tb_hazard_ctrl_mc;

    localparam int AW = 5;
    localparam int CW = 4;

    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] S3   = 6'b111000;
    localparam logic [5:0] LU   = 6'b110010;
    localparam logic [5:0] FL   = 6'b000110;
    localparam logic [5:0] TR   = 6'b100111;

    logic          clk = 1'b0;
    logic          rst;
    logic          RegWrite_EM, RegWrite_MW, MemRead_DE;
    logic          Branch_taken, mdu_start, Overflow, Break;
    logic          uses_rt_FD;
    logic [AW-1:0] WriteReg_EM, WriteReg_MW;
    logic [AW-1:0] RS_DE, RT_DE, RS_FD, RT_FD;
    logic [1:0]    PCSrc, ForwardA, ForwardB;
    logic          Stall_PC, Stall_FD, Stall_DE;
    logic          flush_FD, flush_DE, trap_busy;
    logic [CW-1:0] stall_count;

    hazard_ctrl_mc #(
        .REG_AW(AW), .MDU_LAT(4), .TRAP_DRAIN(2), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .RegWrite_EM(RegWrite_EM), .RegWrite_MW(RegWrite_MW),
        .MemRead_DE(MemRead_DE), .Branch_taken(Branch_taken),
        .mdu_start(mdu_start), .Overflow(Overflow), .Break(Break),
        .uses_rt_FD(uses_rt_FD),
        .WriteReg_EM(WriteReg_EM), .WriteReg_MW(WriteReg_MW),
        .RS_DE(RS_DE), .RT_DE(RT_DE), .RS_FD(RS_FD), .RT_FD(RT_FD),
        .PCSrc(PCSrc), .ForwardA(ForwardA), .ForwardB(ForwardB),
        .Stall_PC(Stall_PC), .Stall_FD(Stall_FD), .Stall_DE(Stall_DE),
        .flush_FD(flush_FD), .flush_DE(flush_DE),
        .trap_busy(trap_busy), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        logic [11:0]   ctl;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sb[$];
    int            n_chk = 0;
    int            n_err = 0;
    logic [CW-1:0] mcnt  = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] outs();
        return {PCSrc, ForwardA, ForwardB, Stall_PC, Stall_FD, Stall_DE,
                flush_FD, flush_DE, trap_busy};
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, ".ctl"}, 32'(outs()), 32'(e.ctl));
            chk({e.tag, ".cnt"}, 32'(stall_count), 32'(e.cnt));
        end
    end

    // queue one cycle's expectation, advance the count model, move on
    task automatic step(input string tag, input logic [1:0] pc,
                        input logic [1:0] fa, input logic [1:0] fb,
                        input logic [5:0] c);
        exp_t e;
        e.tag = tag;
        e.ctl = {pc, fa, fb, c};
        e.cnt = mcnt;
        sb.push_back(e);
        if (c[5] && mcnt != {CW{1'b1}}) mcnt = mcnt + 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        RegWrite_EM = 0; RegWrite_MW = 0; MemRead_DE = 0;
        Branch_taken = 0; mdu_start = 0; Overflow = 0; Break = 0;
        uses_rt_FD = 0;
        WriteReg_EM = 0; WriteReg_MW = 0;
        RS_DE = 0; RT_DE = 0; RS_FD = 0; RT_FD = 0;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctl", 32'(outs()), 32'h0);
        chk("rst_cnt", 32'(stall_count), 32'h0);
        chk("rst_trap", 32'(trap_busy), 32'h0);
        rst = 1'b0;
        mcnt = '0;
        @(posedge clk);
        #1;

        step("idle", 2'b00, 2'b00, 2'b00, NONE);

        RegWrite_EM = 1; WriteReg_EM = 3; RS_DE = 3;
        RegWrite_MW = 1; WriteReg_MW = 4; RT_DE = 4;
        step("fwd_em_mw", 2'b00, 2'b10, 2'b01, NONE);
        RT_DE = 3; WriteReg_MW = 3;
        step("fwd_both_em", 2'b00, 2'b10, 2'b10, NONE);
        WriteReg_EM = 0; RT_DE = 4; WriteReg_MW = 4;
        step("fwd_r0", 2'b00, 2'b00, 2'b01, NONE);
        clr();

        MemRead_DE = 1; RT_DE = 5; RT_FD = 5;
        step("lu_no_rt", 2'b00, 2'b00, 2'b00, NONE);
        uses_rt_FD = 1;
        step("lu_rt", 2'b00, 2'b00, 2'b00, LU);
        uses_rt_FD = 0; RT_FD = 0; RS_FD = 5;
        step("lu_rs", 2'b00, 2'b00, 2'b00, LU);
        RT_DE = 0; RS_FD = 0;
        step("lu_r0", 2'b00, 2'b00, 2'b00, NONE);
        RT_DE = 5; RS_FD = 5; Branch_taken = 1;
        step("br_over_lu", 2'b01, 2'b00, 2'b00, FL);
        clr();

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mcnt = '0;

        mdu_start = 1;
        step("mdu0", 2'b00, 2'b00, 2'b00, S3);
        mdu_start = 0; Branch_taken = 1;
        step("mdu1_br", 2'b00, 2'b00, 2'b00, S3);
        Branch_taken = 0; MemRead_DE = 1; RT_DE = 5; RS_FD = 5;
        step("mdu2_lu", 2'b00, 2'b00, 2'b00, S3);
        clr();
        step("mdu3", 2'b00, 2'b00, 2'b00, S3);
        step("mdu_done", 2'b00, 2'b00, 2'b00, NONE);

        mdu_start = 1;
        step("mx0", 2'b00, 2'b00, 2'b00, S3);
        mdu_start = 0;
        step("mx1", 2'b00, 2'b00, 2'b00, S3);
        Overflow = 1;
        step("mx_ovf", 2'b11, 2'b00, 2'b00, FL);
        Overflow = 0; Break = 1;
        step("trap0_brk", 2'b00, 2'b00, 2'b00, TR);
        Break = 0; Branch_taken = 1;
        step("trap1_br", 2'b00, 2'b00, 2'b00, TR);
        step("post_trap_br", 2'b01, 2'b00, 2'b00, FL);
        clr();

        Overflow = 1; mdu_start = 1; Branch_taken = 1;
        step("run_ovf", 2'b11, 2'b00, 2'b00, FL);
        clr();
        step("trap_a", 2'b00, 2'b00, 2'b00, TR);
        rst = 1'b1;
        #1;
        chk("rst_mid_trap", 32'(trap_busy), 32'h0);
        chk("rst_mid_stall", 32'(Stall_PC), 32'h0);
        chk("rst_mid_cnt", 32'(stall_count), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mcnt = '0;

        mdu_start = 1;
        for (int i = 0; i < 20; i++)
            step($sformatf("sat%0d", i), 2'b00, 2'b00, 2'b00, S3);
        mdu_start = 0;
        step("sat_end", 2'b00, 2'b00, 2'b00, NONE);

        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(posedge clk);
        if (sb.size() > 0)
            chk("drain", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_mc.md
Name: hazard_ctrl_mc

Overview:
- Next-generation hazard unit for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Combinational forwarding and load-use detection, now with independent per-operand forwarding priority and an rt-usage qualifier.
- Adds a sequential controller: a multi-cycle MDU stall counter, a multi-cycle trap drain sequence after Overflow/Break, and a saturating stall-cycle performance counter.
- Sits beside the datapath and drives the PC mux, forwarding muxes and pipeline-register stall/flush controls.

Parameters:
- REG_AW, 5, register-address width.
- MDU_LAT, 4, EX-stage stall cycles per mult/div; must be >= 1.
- TRAP_DRAIN, 2, cycles held in TRAP after an exception is taken; must be >= 1.
- CNT_W, 16, width of stall_count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- RegWrite_EM  in  1  EX/MEM instruction writes the register file.
- RegWrite_MW  in  1  MEM/WB instruction writes the register file.
- MemRead_DE  in  1  ID/EX instruction is a load.
- Branch_taken  in  1  branch/jump resolved taken in EX.
- mdu_start  in  1  ID/EX instruction is mult/div.
- Overflow  in  1  arithmetic overflow in EX.
- Break  in  1  break instruction in EX.
- uses_rt_FD  in  1  IF/ID instruction reads rt.
- WriteReg_EM  in  REG_AW  destination register in EX/MEM.
- WriteReg_MW  in  REG_AW  destination register in MEM/WB.
- RS_DE, RT_DE  in  REG_AW  source registers in ID/EX.
- RS_FD, RT_FD  in  REG_AW  source registers in IF/ID.
- PCSrc  out  2  00 = PC+4, 01 = branch target, 11 = exception vector.
- ForwardA, ForwardB  out  2  00 = register file, 10 = EX/MEM, 01 = MEM/WB.
- Stall_PC, Stall_FD, Stall_DE  out  1  hold the PC / IF/ID / ID/EX register.
- flush_FD, flush_DE  out  1  bubble IF/ID / ID/EX.
- trap_busy  out  1  high while in TRAP.
- stall_count  out  CNT_W  saturating count of cycles with Stall_PC = 1.

Behaviour:
- Reset: state = RUN, internal counter = 0, stall_count = 0. All other outputs are combinational, so every output is 0 when inputs are 0.
- Forwarding is combinational and evaluated in every state, separately for each operand X in {RS_DE→ForwardA, RT_DE→ForwardB}:
  - 10 if RegWrite_EM, WriteReg_EM != 0 and X == WriteReg_EM;
  - else 01 if RegWrite_MW, WriteReg_MW != 0 and X == WriteReg_MW;
  - else 00.
  - A hit on one operand never suppresses forwarding of the other.
- States: RUN, MDU_WAIT, TRAP. Outputs are listed per state in priority order.
- Exception (Overflow | Break) in RUN or MDU_WAIT, same cycle:
  - PCSrc = 11, flush_FD = 1, flush_DE = 1, Stall_PC = 0 (vector loads).
  - Next state TRAP, counter = TRAP_DRAIN-1.
  - Aborts MDU_WAIT. Ignored while in TRAP.
- TRAP:
  - Stall_PC = 1, flush_FD = 1, flush_DE = 1, trap_busy = 1, PCSrc = 00.
  - Counter 0 → next state RUN; otherwise decrement.
  - Branch, load-use and mdu_start are ignored.
- MDU_WAIT, no exception:
  - Stall_PC = Stall_FD = Stall_DE = 1; Branch_taken and load-use ignored.
  - Counter 0 → next state RUN; otherwise decrement.
- RUN, mdu_start and no exception:
  - Stalls asserted this cycle as in MDU_WAIT.
  - If MDU_LAT > 1: next state MDU_WAIT, counter = MDU_LAT-2.
  - Total stall length is exactly MDU_LAT cycles.
- RUN, Branch_taken, no exception, no mdu_start: PCSrc = 01, flush_FD = 1, flush_DE = 1, no stall; overrides load-use.
- RUN, load-use, none of the above:
  - Condition: MemRead_DE, RT_DE != 0, and (RT_DE == RS_FD or (uses_rt_FD and RT_DE == RT_FD)).
  - Response: Stall_PC = Stall_FD = 1, flush_DE = 1 (one bubble).
- stall_count increments on every clock edge where Stall_PC = 1 and saturates at all ones.
- Reset asserted mid-MDU_WAIT or mid-TRAP returns to RUN immediately (asynchronous).

Test Plan:
- Reset, all inputs 0 → all outputs 0, stall_count 0, trap_busy 0.
- RegWrite_EM = 1, WriteReg_EM = 3, RS_DE = 3; RegWrite_MW = 1, WriteReg_MW = 4, RT_DE = 4 → ForwardA = 10, ForwardB = 01. Set WriteReg_EM = 0 → ForwardA = 00.
- MemRead_DE = 1, RT_DE = 5, RT_FD = 5, uses_rt_FD = 0 → no stall. uses_rt_FD = 1 → Stall_PC = Stall_FD = flush_DE = 1 for one cycle.
- mdu_start pulsed 1 cycle, MDU_LAT = 4 → Stall_DE high exactly 4 cycles, back to RUN, stall_count = 4. Branch_taken during the wait → PCSrc stays 00.
- Overflow in cycle 2 of MDU_WAIT → PCSrc = 11 and flushes that cycle, then trap_busy = 1 with Stall_PC = 1 for 2 cycles (TRAP_DRAIN = 2), then RUN. Break during TRAP → ignored.
- Drive Stall_PC continuously with CNT_W = 4 → stall_count saturates at 15. Assert rst mid-TRAP → trap_busy = 0 immediately.
